// File: rtl/cmos_cfg_sequencer.sv
// CMOS sensor register-table sequencer: power-up settle, then streams LUT
// entries to an SCCB master with per-entry retries and 0xFFFF delay entries.
module cmos_cfg_sequencer #(
  parameter logic [9:0]  LUT_SIZE     = 10'd300,
  parameter logic [19:0] PWRUP_CYCLES = 20'd480000,
  parameter logic [15:0] DELAY_UNIT   = 16'd24000,
  parameter logic [1:0]  RETRY_MAX    = 2'd3
) (
  input  logic        clk_cmos,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic [9:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        sccb_req,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_ack,
  input  logic        sccb_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [9:0]  cfg_fail_index
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PWR_WAIT = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_DELAY    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_FAIL     = 3'd7;

  localparam logic [9:0] LAST_IDX = LUT_SIZE - 10'd1;

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        fetch_ph_q, fetch_ph_d;
  logic [1:0]  retry_q, retry_d;
  logic [9:0]  lut_index_q, lut_index_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [9:0]  fail_idx_q, fail_idx_d;

  logic        advance;
  logic [2:0]  retry_inc;
  logic [23:0] dly_cycles;

  assign retry_inc  = {1'b0, retry_q} + 3'd1;
  assign dly_cycles = 24'(lut_data[7:0]) * 24'(DELAY_UNIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fetch_ph_d  = fetch_ph_q;
    retry_d     = retry_q;
    lut_index_d = lut_index_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fail_idx_d  = fail_idx_q;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_PWR_WAIT;
        cnt_d   = {4'b0, PWRUP_CYCLES};
      end
      S_PWR_WAIT: begin
        if (cnt_q <= 24'd1) begin
          lut_index_d = '0;
          retry_d     = '0;
          fetch_ph_d  = 1'b0;
          state_d     = (LUT_SIZE == 10'd0) ? S_DONE : S_FETCH;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          addr_d     = lut_data[23:8];
          wdata_d    = lut_data[7:0];
          if (lut_data[23:8] == 16'hFFFF) begin
            state_d = S_DELAY;
            cnt_d   = dly_cycles;
          end else begin
            state_d = S_ISSUE;
            req_d   = 1'b1;
          end
        end
      end
      // Entered from FETCH with req already high; entered on a retry with req
      // low, which makes this cycle the mandatory idle gap before re-requesting.
      S_ISSUE: begin
        req_d   = 1'b1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (sccb_err) begin
          req_d   = 1'b0;
          retry_d = retry_inc[1:0];
          if (retry_inc < {1'b0, RETRY_MAX}) begin
            state_d = S_ISSUE;
          end else begin
            fail_idx_d = lut_index_q;
            state_d    = S_FAIL;
          end
        end else if (sccb_ack) begin
          req_d   = 1'b0;
          advance = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q <= 24'd1) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_DONE, S_FAIL: begin
        if (cfg_start) begin
          lut_index_d = '0;
          retry_d     = '0;
          fetch_ph_d  = 1'b0;
          state_d     = (LUT_SIZE == 10'd0) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (lut_index_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        lut_index_d = lut_index_q + 10'd1;
        retry_d     = '0;
        fetch_ph_d  = 1'b0;
        state_d     = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk_cmos or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fetch_ph_q  <= 1'b0;
      retry_q     <= '0;
      lut_index_q <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fail_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetch_ph_q  <= fetch_ph_d;
      retry_q     <= retry_d;
      lut_index_q <= lut_index_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign lut_index      = lut_index_q;
  assign sccb_req       = req_q;
  assign sccb_addr      = addr_q;
  assign sccb_wdata     = wdata_q;
  assign cfg_busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
  assign cfg_done       = (state_q == S_DONE);
  assign cfg_error      = (state_q == S_FAIL);
  assign cfg_fail_index = fail_idx_q;

endmodule

// File: doc/cmos_cfg_sequencer.md
CMOS_CFG_SEQUENCER -- requirements
Module: cmos_cfg_sequencer

Interface
REQ-001 Parameter LUT_SIZE, default 10'd300: number of valid entries in the register table.
REQ-002 Parameter PWRUP_CYCLES, default 20'd480000: post-reset settle wait (20 ms at 24 MHz).
REQ-003 Parameter DELAY_UNIT, default 16'd24000: cycles per delay unit (1 ms at 24 MHz).
REQ-004 Parameter RETRY_MAX, default 2'd3: total SCCB attempts allowed per entry.
REQ-005 clk_cmos  input  1  24 MHz CMOS driver clock; all logic on its rising edge.
REQ-006 rst_n  input  1  global reset; asynchronous, active-low.
REQ-007 cfg_start  input  1  one-cycle pulse requesting reconfiguration.
REQ-008 lut_index  output  10  table address.
REQ-009 lut_data  input  24  table entry {reg_addr[23:8], reg_val[7:0]}, valid one cycle after lut_index changes.
REQ-010 sccb_req  output  1  write request to the SCCB master.
REQ-011 sccb_addr  output  16  register address for the request.
REQ-012 sccb_wdata  output  8  register value for the request.
REQ-013 sccb_ack  input  1  one-cycle pulse: write completed.
REQ-014 sccb_err  input  1  one-cycle pulse: write NACKed.
REQ-015 cfg_busy  output  1  high whenever not in IDLE, DONE or FAIL.
REQ-016 cfg_done  output  1  high in DONE; gates release of capture logic.
REQ-017 cfg_error  output  1  high in FAIL.
REQ-018 cfg_fail_index  output  10  lut_index of the entry that exhausted its retries.

Function
REQ-019 States: IDLE, PWR_WAIT, FETCH, ISSUE, WAIT_ACK, DELAY, DONE, FAIL.
REQ-020 On reset release, IDLE moves to PWR_WAIT unconditionally on the next cycle.
REQ-021 PWR_WAIT counts PWRUP_CYCLES cycles, then goes to FETCH with lut_index=0.
REQ-022 FETCH lasts exactly 2 cycles: address setup, then register lut_data.
REQ-023 If the registered reg_addr is 16'hFFFF, go to DELAY: wait reg_val*DELAY_UNIT cycles; reg_val=0 gives a 1-cycle pass-through.
REQ-024 Otherwise go to ISSUE: assert sccb_req with sccb_addr/sccb_wdata, then go to WAIT_ACK.
REQ-025 sccb_req, sccb_addr and sccb_wdata hold stable until sccb_ack or sccb_err is sampled high; sccb_req drops the next cycle.
REQ-026 Within the same entry, one idle cycle (req low) separates consecutive requests.
REQ-027 On sccb_ack, or when DELAY ends: if lut_index==LUT_SIZE-1, go to DONE; otherwise increment lut_index, clear the retry count and go to FETCH.
REQ-028 On sccb_err, increment the retry count. If count<RETRY_MAX, reissue the same entry via ISSUE after the idle cycle; otherwise latch cfg_fail_index and go to FAIL.
REQ-029 If sccb_ack and sccb_err are high in the same cycle, sccb_err takes priority.
REQ-030 While not in WAIT_ACK, sccb_ack and sccb_err are ignored.
REQ-031 In DONE or FAIL, cfg_start clears lut_index, retry count, cfg_error and cfg_done, then goes to FETCH, skipping PWR_WAIT.
REQ-032 In any other state, cfg_start is ignored.
REQ-033 LUT_SIZE=0 goes directly from PWR_WAIT to DONE without issuing any request.
REQ-034 Delay counter width is 24 bits; 8-bit reg_val times 16-bit DELAY_UNIT never overflows.

Reset
REQ-035 While rst_n=0 the state is IDLE and all outputs are 0: sccb_req, sccb_addr, sccb_wdata, lut_index, cfg_busy, cfg_done, cfg_error and cfg_fail_index.
REQ-036 Reset asserted mid-transaction drops sccb_req immediately; no partial state survives.
REQ-037 After reset the full sequence, including PWR_WAIT, restarts.

Verification
REQ-038 LUT_SIZE=3, PWRUP_CYCLES=10, table {3008_82, 3103_03, 3017_FF}, ack 5 cycles after each req -> three requests in order, each with stable addr/data; cfg_done=1 after the third ack; first sccb_req rises 13 cycles after reset release.
REQ-039 Entry FFFF_02 with DELAY_UNIT=100 -> no sccb_req for 200 cycles, then the next entry is fetched.
REQ-040 sccb_err on two attempts, then ack -> 3 requests for the same entry, 1 idle cycle between them; the sequence continues.
REQ-041 sccb_err on 3 attempts at index 5 -> cfg_error=1, cfg_fail_index=5, cfg_busy=0. A following cfg_start gives sccb_req for index 0 after 2 FETCH cycles, without the power-up wait.
REQ-042 ack and err pulsed in the same cycle -> treated as an error, retry count incremented.
REQ-043 rst_n low while sccb_req is high -> sccb_req=0 asynchronously; after release, PWR_WAIT restarts and lut_index=0.
